// File: rtl/aes_key_expand.sv
// AES-128 key schedule: emits round keys 0..10 over a valid/ready handshake.
// Optional stored-key read port enabled by AES_KEY_EXPAND_STORE_EN.

// Four AES S-boxes, computed as GF(2^8) inverse followed by the affine map.
module aes_sbox_word (
    input  logic [31:0] din,
    output logic [31:0] dout
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        // x^254 is the multiplicative inverse, and maps 0 to 0
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            dout[i*8 +: 8] = sbox(din[i*8 +: 8]);
        end
    end
endmodule

module aes_key_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_num,
    output logic         rk_valid,
    output logic         busy,
    output logic         done,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);
    localparam int unsigned KEY_W    = 128;
    localparam int unsigned RND_W    = 4;
    localparam int unsigned NUM_KEYS = 11;
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_KEYS - 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t           state_q, state_d;
    logic [KEY_W-1:0] key_d;
    logic [RND_W-1:0] rnd_d;
    logic [7:0]       rcon_q, rcon_d;
    logic             valid_d, busy_d, done_d;
    logic [31:0]      sub_word, t_word;
    logic [31:0]      w0n, w1n, w2n, w3n;

    // Next round key from the current one
    aes_sbox_word u_sbox (
        .din  ({round_key[23:0], round_key[31:24]}),
        .dout (sub_word)
    );

    assign t_word = sub_word ^ {rcon_q, 24'h000000};
    assign w0n    = round_key[127:96] ^ t_word;
    assign w1n    = round_key[95:64]  ^ w0n;
    assign w2n    = round_key[63:32]  ^ w1n;
    assign w3n    = round_key[31:0]   ^ w2n;

    always_comb begin
        state_d = state_q;
        key_d   = round_key;
        rnd_d   = round_num;
        rcon_d  = rcon_q;
        valid_d = rk_valid;
        busy_d  = busy;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EMIT;
                    key_d   = key_in;
                    rnd_d   = '0;
                    rcon_d  = 8'h01;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (round_num == LAST_RND) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        key_d  = {w0n, w1n, w2n, w3n};
                        rnd_d  = round_num + RND_W'(1);
                        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            round_key <= '0;
            round_num <= '0;
            rcon_q    <= 8'h01;
            rk_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            round_key <= key_d;
            round_num <= rnd_d;
            rcon_q    <= rcon_d;
            rk_valid  <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

`ifdef AES_KEY_EXPAND_STORE_EN
    logic [KEY_W-1:0] store_q [NUM_KEYS];

    // Rewriting the same entry while stalled is harmless
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_KEYS); i++) store_q[i] <= '0;
        end else if (rk_valid) begin
            store_q[round_num] <= round_key;
        end
    end

    assign rd_key = (rd_idx > LAST_RND) ? '0 : store_q[rd_idx];
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^rd_idx;
    assign rd_key        = '0;
`endif
endmodule
